risc8_bus_target: RTL



---
 rtl/risc8_bus_target.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/risc8_bus_target.sv
`default_nettype none
// ============================================================================
//  Module   : risc8_bus_target
//  Purpose  : Bus responder on the far side of the risc8 external bus.
//             Claims iack cycles and accesses to a 2^ADDR_BITS byte RAM
//             window at BASE_ADDR. Inserts RD_WAIT/WR_WAIT wait states,
//             serves the RAM and returns IRQ_VECTOR on iack.
//  Ports    : clk, rst (async, active-high)
//             cycle/write/ifetch/iack/address/data_out : CPU request side
//             ready    : one-clock transfer-complete strobe (registered)
//             data_in  : read data, held until the next read completes
//             hit      : set while a claimed transfer is in progress
//             bus_err  : one-clock timeout pulse (RISC8_BUS_TIMEOUT_EN only)
//  Options  : define RISC8_BUS_TIMEOUT_EN to complete unclaimed cycles with
//             data 8'hFF and bus_err after 16 idle clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module risc8_bus_target #(
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 0,
  parameter logic [7:0]  IRQ_VECTOR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cycle,
  input  logic        write,
  input  logic        ifetch,
  input  logic        iack,
  input  logic [15:0] address,
  input  logic [7:0]  data_out,
  output logic        ready,
  output logic [7:0]  data_in,
  output logic        hit
`ifdef RISC8_BUS_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic                 iack_q, iack_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           data_in_q, data_in_d;
  logic                 hit_q, hit_d;
  logic                 timeout;
`ifdef RISC8_BUS_TIMEOUT_EN
  logic [3:0]           tcnt_q, tcnt_d;
  logic                 bus_err_q, bus_err_d;
`endif

  logic [7:0] mem [0:(1<<ADDR_BITS)-1];

  logic claim;
  assign claim = iack | (address[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

  // State register and all other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      iack_q    <= 1'b0;
      wdata_q   <= 8'h00;
      data_in_q <= 8'h00;
      hit_q     <= 1'b0;
`ifdef RISC8_BUS_TIMEOUT_EN
      tcnt_q    <= 4'd0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      iack_q    <= iack_d;
      wdata_q   <= wdata_d;
      data_in_q <= data_in_d;
      hit_q     <= hit_d;
`ifdef RISC8_BUS_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

  // Next-state logic. The *_d copies of the request fields hold the live
  // inputs on the IDLE->busy transition and the latched values afterwards,
  // so the ACK-entry data load below can use them uniformly.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    iack_d    = iack_q;
    wdata_d   = wdata_q;
    data_in_d = data_in_q;
    hit_d     = hit_q;
    timeout   = 1'b0;
`ifdef RISC8_BUS_TIMEOUT_EN
    tcnt_d    = 4'd0;
    bus_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cycle && claim) begin
          addr_d  = address[ADDR_BITS-1:0];
          // An ifetch is always a read, and iack never writes.
          wr_d    = write & ~ifetch & ~iack;
          iack_d  = iack;
          wdata_d = data_out;
          if (iack)      wcnt_d = 4'd0;
          else if (wr_d) wcnt_d = 4'(WR_WAIT);
          else           wcnt_d = 4'(RD_WAIT);
          state_d = (wcnt_d == 4'd0) ? S_ACK : S_WAIT;
          hit_d   = 1'b1;
        end
`ifdef RISC8_BUS_TIMEOUT_EN
        else if (cycle) begin
          if (tcnt_q == 4'd15) begin
            timeout   = 1'b1;
            state_d   = S_ACK;
            bus_err_d = 1'b1;
            wr_d      = 1'b0;   // a timed-out write must not touch RAM
            iack_d    = 1'b0;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
`endif
      end
      S_WAIT: begin
        if (!cycle) begin
          state_d = S_IDLE;
          wcnt_d  = 4'd0;
          hit_d   = 1'b0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        hit_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        hit_d   = 1'b0;
      end
    endcase

    // Read data is captured on entry to ACK; writes leave data_in alone.
    if (state_q != S_ACK && state_d == S_ACK) begin
      if (timeout)    data_in_d = 8'hFF;
      else if (iack_d) data_in_d = IRQ_VECTOR;
      else if (!wr_d) data_in_d = mem[addr_d];
    end
  end

  // Outputs: decoded from flops only, never from cycle.
  always_comb begin
    ready   = (state_q == S_ACK);
    data_in = data_in_q;
    hit     = hit_q;
`ifdef RISC8_BUS_TIMEOUT_EN
    bus_err = bus_err_q;
`endif
  end

  // RAM is not reset; it is written on the completing (ACK) edge.
  always_ff @(posedge clk) begin
    if (state_q == S_ACK && wr_q) mem[addr_q] <= wdata_q;
  end

endmodule
`default_nettype wire
